// File: rtl/alu_hs_pkg.sv
`default_nettype none
// alu_hs_pkg: opcodes, FSM state type and opcode legality for alu_hs.
// Opcode C is legal only when ALU_HS_MUL_EN is defined.
package alu_hs_pkg;

  localparam logic [3:0] OP_HLT = 4'h0;
  localparam logic [3:0] OP_SKZ = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LDA = 4'h5;
  localparam logic [3:0] OP_STO = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_SUB = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_legal(input logic [3:0] op);
`ifdef ALU_HS_MUL_EN
    return (op <= OP_MUL);
`else
    return (op <= OP_SHR);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_hs_mul.sv
`default_nettype none
// alu_hs_mul: iterative shift-add multiplier, one partial product per clock, DATA_W clocks.
// Built only when ALU_HS_MUL_EN is defined.
`ifdef ALU_HS_MUL_EN
module alu_hs_mul #(
  parameter int DATA_W = 8
) (
  input  logic              alu_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] p
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;

  // done and p describe the final iteration while it is in flight, so the
  // consumer can register the product on the same edge that retires it.
  assign acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
  assign done  = busy_q && (cnt_q == CW'(DATA_W - 1));
  assign p     = acc_d;
  assign busy  = busy_q;

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/alu_hs.sv
`default_nettype none
// alu_hs: handshaked accumulator ALU with registered result and flags.
// ALU_HS_MUL_EN adds the iterative multiply on opcode C; otherwise C is illegal.
module alu_hs
  import alu_hs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              alu_clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] accum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic              carry,
  output logic              neg,
  output logic              ovf,
  output logic              illegal
);

  localparam int SHW = $clog2(DATA_W);
  localparam int MSB = DATA_W - 1;

  state_e            state_q;
  logic [DATA_W-1:0] alu_out_q;
  logic              zero_q;
  logic              carry_q;
  logic              neg_q;
  logic              ovf_q;
  logic              illegal_q;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] res_d;
  logic              carry_d;
  logic              ovf_d;
  logic              illegal_d;
  logic              accept;
  logic              mul_start;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

  assign sum  = {1'b0, accum} + {1'b0, data};
  assign diff = {1'b0, accum} - {1'b0, data};

  // Bit DATA_W of diff is the borrow out of the unsigned subtraction.
  always_comb begin
    res_d     = accum;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    illegal_d = !is_legal(opcode);
    case (opcode)
      OP_ADD: begin
        res_d   = sum[DATA_W-1:0];
        carry_d = sum[DATA_W];
        ovf_d   = (accum[MSB] == data[MSB]) && (sum[MSB] != accum[MSB]);
      end
      OP_SUB: begin
        res_d   = diff[DATA_W-1:0];
        carry_d = diff[DATA_W];
        ovf_d   = (accum[MSB] != data[MSB]) && (diff[MSB] != accum[MSB]);
      end
      OP_AND:  res_d = accum & data;
      OP_XOR:  res_d = accum ^ data;
      OP_OR:   res_d = accum | data;
      OP_LDA:  res_d = data;
      OP_SHL:  res_d = accum << data[SHW-1:0];
      OP_SHR:  res_d = accum >> data[SHW-1:0];
      default: res_d = accum;
    endcase
  end

`ifdef ALU_HS_MUL_EN
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_p;

  assign mul_start = accept && (opcode == OP_MUL);

  alu_hs_mul #(
    .DATA_W(DATA_W)
  ) u_mul (
    .alu_clk(alu_clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (accum),
    .b      (data),
    .busy   (mul_busy),
    .done   (mul_done),
    .p      (mul_p)
  );
`else
  assign mul_start = 1'b0;
`endif

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else if (mul_start) begin
      state_q <= BUSY;
    end else if (accept) begin
      state_q   <= DONE;
      alu_out_q <= res_d;
      zero_q    <= (res_d == '0);
      carry_q   <= carry_d;
      neg_q     <= res_d[MSB];
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end else begin
      case (state_q)
        BUSY: begin
`ifdef ALU_HS_MUL_EN
          if (mul_done) begin
            state_q   <= DONE;
            alu_out_q <= mul_p;
            zero_q    <= (mul_p == '0);
            carry_q   <= 1'b0;
            neg_q     <= mul_p[MSB];
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
          end else if (!mul_busy) begin
            state_q <= IDLE;
          end
`else
          state_q <= IDLE;
`endif
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_hs.sv
`default_nettype none
// tb_alu_hs: scoreboard bench for alu_hs (DATA_W=8); expectations follow ALU_HS_MUL_EN.
module tb_alu_hs;

  localparam int W = 8;

  logic         alu_clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] data;
  logic [W-1:0] accum;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         zero, carry, neg, ovf, illegal;

  alu_hs #(.DATA_W(W)) dut (
    .alu_clk  (alu_clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .data     (data),
    .accum    (accum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .zero     (zero),
    .carry    (carry),
    .neg      (neg),
    .ovf      (ovf),
    .illegal  (illegal)
  );

  always #5 alu_clk = ~alu_clk;

  typedef struct packed {
    logic [7:0] res;
    logic [4:0] fl;  // {zero, carry, neg, ovf, illegal}
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  bit   rnd_bp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ia, ib, r, sa, sb_s, ss;
    logic c, v, il;
    ia = int'(a); ib = int'(b);
    sa   = (ia >= 128) ? ia - 256 : ia;
    sb_s = (ib >= 128) ? ib - 256 : ib;
    r = ia; c = 1'b0; v = 1'b0; il = 1'b0;
    case (op)
      4'h2: begin r = ia + ib; c = (r > 255); ss = sa + sb_s; v = (ss > 127) || (ss < -128); end
      4'h8: begin r = ia - ib; c = (ia < ib); ss = sa - sb_s; v = (ss > 127) || (ss < -128); end
      4'h3: r = ia & ib;
      4'h4: r = ia ^ ib;
      4'h9: r = ia | ib;
      4'h5: r = ib;
      4'hA: r = ia * (1 << (ib % 8));
      4'hB: r = ia / (1 << (ib % 8));
`ifdef ALU_HS_MUL_EN
      4'hC: r = ia * ib;
`else
      4'hC: il = 1'b1;
`endif
      4'hD, 4'hE, 4'hF: il = 1'b1;
      default: r = ia;
    endcase
    e.res = r[7:0];
    e.fl  = {(e.res == 8'h00), c, e.res[7], v, il};
    return e;
  endfunction

  // Sampled on the falling edge: a result seen here with out_ready high is consumed on the next rise.
  always @(negedge alu_clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(alu_out), 32'(e.res));
        chk("flags", 32'({zero, carry, neg, ovf, illegal}), 32'(e.fl));
      end
      n_out++;
    end
  end

  always @(posedge alu_clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    in_valid = 1'b1; opcode = op; accum = a; data = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge alu_clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (ok) sb.push_back(model(op, a, b));
    else    chk("accept_timeout", 32'd0, 32'd1);
    @(posedge alu_clk); #1;
    in_valid = 1'b0; opcode = 4'hF; accum = ~a; data = ~b;
  endtask

  task automatic tick;
    @(posedge alu_clk); #1;
  endtask

  logic [3:0] t_op [0:13] = '{4'h4, 4'h8, 4'hE, 4'hA, 4'hB, 4'h9, 4'h5, 4'h0,
                              4'h1, 4'h6, 4'h7, 4'hD, 4'h2, 4'h8};
  logic [7:0] t_a  [0:13] = '{8'h5A, 8'h00, 8'h33, 8'h81, 8'h81, 8'hA0, 8'h11, 8'h12,
                              8'h34, 8'h56, 8'h78, 8'h9A, 8'hFF, 8'h80};
  logic [7:0] t_b  [0:13] = '{8'h5A, 8'h01, 8'h00, 8'h09, 8'h03, 8'h05, 8'h42, 8'h34,
                              8'h00, 8'h11, 8'h22, 8'h33, 8'h01, 8'h01};

  initial begin
    int w, k, cnt0;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; data = '0; accum = '0; out_ready = 1'b1;
    repeat (2) @(posedge alu_clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_out", 32'(alu_out), 32'd0);
    chk("rst_flags", 32'({zero, carry, neg, ovf, illegal}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    send(4'h2, 8'h7F, 8'h01, w);
    chk("add_latency", 32'(out_valid), 32'd1);
    chk("add_res", 32'(alu_out), 32'h80);
    tick();

    out_ready = 1'b0;
    send(4'h2, 8'h7F, 8'h01, w);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_res", 32'({alu_out, zero, carry, neg, ovf, illegal}), 32'({8'h80, 5'b00110}));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("in_ready_comb", 32'(in_ready), 32'd1);
    cnt0 = n_out;
    for (int i = 0; i < 4; i++) begin
      send(4'h3, 8'(8'hF0 | i), 8'(8'h3C + i), w);
      chk("stream_wait", 32'(w), 32'd0);
    end
    tick();
    chk("stream_count", 32'(n_out - cnt0), 32'd5);

    send(4'hC, 8'h0D, 8'h0B, w);
`ifdef ALU_HS_MUL_EN
    chk("mul_in_ready", 32'(in_ready), 32'd0);
    for (k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) break;
      chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
    end
    chk("mul_latency", 32'(k), 32'd8);
    chk("mul_res", 32'(alu_out), 32'h8F);
`else
    chk("mul_illegal_latency", 32'(out_valid), 32'd1);
    chk("mul_illegal", 32'({alu_out, illegal}), 32'({8'h0D, 1'b1}));
`endif
    tick();

    for (int i = 0; i < 14; i++) begin
      send(t_op[i], t_a[i], t_b[i], w);
      if (t_op[i] == 4'hA) chk("shl_res", 32'(alu_out), 32'h02);
      if (t_op[i] == 4'hE) chk("illegal_res", 32'({alu_out, illegal}), 32'({8'h33, 1'b1}));
    end
    tick();

    send(4'hC, 8'h0D, 8'h0B, w);
    repeat (3) @(posedge alu_clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_regs", 32'({alu_out, zero, carry, neg, ovf, illegal}), 32'd0);
    @(negedge alu_clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    send(4'h5, 8'h99, 8'h42, w);
    chk("lda_after_rst", 32'(alu_out), 32'h42);
    tick();

    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), w);
    end
    rnd_bp = 1'b0;
    @(posedge alu_clk); #2;
    out_ready = 1'b1;

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge alu_clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_hs.md
# alu_hs

Parametrised, handshaked successor to the accumulator ALU of the RISC demo core. It takes one operation per transaction on a valid/ready input channel and returns a registered result plus a full flag set on a valid/ready output channel. Single-cycle ops sustain one result per clock. An optional iterative multiplier adds a multi-cycle op. It sits between the decode/accumulator stage and the accumulator/memory write-back.

## Interface
- DATA_W, 8: operand/result width, ≥4.
- SHW, $clog2(DATA_W): shift-amount width (derived; not overridden).
- alu_clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready at rising edge.
- opcode  in  4  operation code.
- data  in  DATA_W  operand B.
- accum  in  DATA_W  operand A (accumulator).
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- alu_out  out  DATA_W  result.
- zero  out  1  alu_out == 0.
- carry  out  1  ADD carry-out / SUB borrow, else 0.
- neg  out  1  alu_out[DATA_W-1].
- ovf  out  1  signed overflow for ADD/SUB, else 0.
- illegal  out  1  opcode not implemented.

## Operation
- Opcodes: 0 HLT, 1 SKZ, 6 STO, 7 JMP -> accum. 2 ADD -> accum+data. 3 AND. 4 XOR. 5 LDA -> data. 8 SUB -> accum-data. 9 OR. A SHL -> accum << data[SHW-1:0]. B SHR -> logical accum >> data[SHW-1:0]. C MUL -> low DATA_W bits of accum*data. D-F -> illegal.
- Illegal op: alu_out=accum, illegal=1, carry=ovf=0. zero and neg follow alu_out.
- Operands and opcode are captured on accept; inputs may change afterwards.
- FSM states: IDLE, BUSY (MUL only), DONE.
  - IDLE + accept single-cycle op -> DONE.
  - IDLE + accept MUL -> BUSY.
  - BUSY: count DATA_W iterations, then -> DONE.
  - DONE + out_ready + accept -> DONE or BUSY, following the new op.
  - DONE + out_ready, no accept -> IDLE.
  - DONE, !out_ready -> DONE; outputs held stable.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- out_valid = (state==DONE).
- Outputs are stable and unchanged while out_valid && !out_ready.
- All arithmetic is unsigned modulo 2^DATA_W. ovf uses two's-complement sign rules.
- Reset: state IDLE, out_valid=0, alu_out=0, zero=0, carry=0, neg=0, ovf=0, illegal=0, iteration counter=0. Reset mid-BUSY abandons the multiply; no result is emitted.

## Timing
- Single-cycle op accepted at edge N -> out_valid and result visible after edge N. Latency 1.
- MUL accepted at edge N -> out_valid after edge N+DATA_W.
- Back-to-back: with out_ready held high, one single-cycle result per clock.
- in_ready depends combinationally on out_ready. No other combinational input-to-output path.

## Configuration
- ALU_HS_MUL_EN defined: opcode C runs through the iterative shift-add multiplier, taking DATA_W cycles in BUSY.
- ALU_HS_MUL_EN undefined: opcode C is illegal (1-cycle, illegal=1, alu_out=accum). BUSY is unreachable, and the multiplier and counter are not instantiated.

## Structure
- Package alu_hs_pkg holds:
  - opcode localparams (OP_HLT … OP_MUL);
  - the FSM state enum (IDLE/BUSY/DONE);
  - a function is_legal(opcode).
- One sub-module, alu_hs_mul: shift-add iterative multiplier, parametrised by DATA_W.
  - Interface: start, a, b, busy, done, p[DATA_W-1:0].
  - Compiled only under ALU_HS_MUL_EN.

## Test plan
- DATA_W=8, ADD accum=0x7F, data=0x01 -> alu_out=0x80, ovf=1, neg=1, carry=0, zero=0, out_valid one cycle after accept.
- SUB accum=0x00, data=0x01 -> alu_out=0xFF, carry=1, ovf=0. XOR 0x5A^0x5A -> alu_out=0x00, zero=1.
- out_ready low for 3 cycles after an ADD result -> in_ready=0, outputs held. Then stream 4 ANDs with out_ready high -> 4 results on 4 consecutive clocks.
- MUL 0x0D*0x0B (ALU_HS_MUL_EN) -> alu_out=0x8F after exactly 8 cycles, in_ready=0 throughout. Without the macro -> illegal=1, alu_out=0x0D after 1 cycle.
- Opcode 0xE, accum=0x33 -> illegal=1, alu_out=0x33. SHL accum=0x81 by data=0x09 (amount 1) -> 0x02.
- rst_n asserted at cycle 4 of a MUL -> out_valid=0, all flags 0, next-cycle in_ready=1. A following LDA 0x42 -> alu_out=0x42.
